ifmap_packer: RTL and testbench
===============================

IFMAP_PACKER -- requirements
Module: ifmap_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: raw ifmap sample width.
REQ-002 Parameter LEN_WIDTH, default 8: width of the row-length field.
REQ-003 Parameter FILTER_SIZE_WIDTH, default 5: width of the filter-size field.
REQ-004 clk  input  1  single clock; all logic updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins one packed row.
REQ-007 row_len  input  LEN_WIDTH  number of data words in the row; sampled on the start cycle.
REQ-008 filter_size  input  FILTER_SIZE_WIDTH  flush-row length; sampled on the start cycle.
REQ-009 flush_en  input  1  append a zero flush row after the data row; sampled on the start cycle.
REQ-010 in_data  input  DATA_WIDTH  raw sample.
REQ-011 in_valid  input  1  in_data is valid.
REQ-012 in_ready  output  1  packer accepts in_data this cycle.
REQ-013 out_data  output  DATA_WIDTH+2  {tag[1:0], sample}; feeds the IFmap buffer input.
REQ-014 out_valid  output  1  out_data is valid; drives the IFmap buffer write enable.
REQ-015 out_ready  input  1  IFmap buffer ready.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when the last word of the job has transferred.

Function
REQ-018 The block SHALL complete a transfer on any rising edge where both valid and ready of that port are high.
REQ-019 The FSM SHALL use these states and transitions:
- IDLE -> DATA on start with row_len≠0.
- IDLE -> FLUSH on start with row_len=0, flush_en=1 and filter_size≠0.
- IDLE -> DONE on start when neither row has any words.
- DATA -> FLUSH or DONE after the last data word is accepted.
- FLUSH -> DONE after the last flush word is accepted.
- DONE -> IDLE unconditionally.
REQ-020 start SHALL be ignored outside IDLE, and the latched row_len, filter_size and flush_en SHALL NOT change until the next IDLE.
REQ-021 The output stage SHALL be a single register: out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 in_ready SHALL equal (state==DATA) && (!out_valid || out_ready); the block SHALL accept input and drain output in the same cycle at full throughput.
REQ-023 Tag rules, per row:
- first word = 2'b10
- last word = 2'b01
- middle words = 2'b00
- a row of length 1 = 2'b11
REQ-024 In FLUSH the block SHALL generate filter_size words with sample 0, tagged per REQ-023, with no input handshake.
REQ-025 A flush row SHALL be skipped when flush_en=0 or filter_size=0.
REQ-026 Latency from input accept to out_valid SHALL be 1 cycle; there SHALL be no bubble between the data row and the flush row when out_ready is held high.
REQ-027 The word counter SHALL be LEN_WIDTH bits, compare against (length−1) for the last word, and never wrap within a row.
REQ-028 done SHALL rise in the cycle after the final out transfer and SHALL last exactly 1 cycle.
REQ-029 When in_valid drops mid-row, the block SHALL hold position and SHALL NOT emit a word.
REQ-030 When out_ready drops mid-row, the block SHALL deassert in_ready and stall both the input side and the FLUSH generation.

Reset
REQ-031 With reset=0 at a rising edge, the block SHALL set state=IDLE, clear counters, and drive out_valid=0, out_data=0, in_ready=0, busy=0, done=0.
REQ-032 Reset mid-row SHALL abandon the row with no further outputs; start SHALL be honoured on the first cycle after reset=1.

Verification
REQ-033 Row: row_len=12, flush_en=0, samples 1..12, out_ready=1 -> 12 words: 0x20001, then 0x00002 through 0x0000B, then 0x1000C; done pulses once.
REQ-034 Flush: row_len=12, filter_size=5, flush_en=1 -> 12 data words, then 0x20000, 0x00000, 0x00000, 0x00000, 0x10000 with no gap.
REQ-035 Backpressure: out_ready toggles 1,0,0,1 repeating while streaming row_len=4 -> no word dropped or duplicated; out_data stable during every stall; order and tags correct.
REQ-036 Corner lengths: row_len=1 with sample 7 -> single word 0x30007. row_len=0 with flush_en=0 -> no out_valid, done pulses 2 cycles after start.
REQ-037 Reset during row: reset=0 after 3 of 8 words -> out_valid=0 next cycle; a new start with row_len=2 yields 0x2xxxx, 0x1xxxx.
REQ-038 Start while busy: start during DATA -> ignored; word count and done timing unchanged.

Source files
------------

// File: rtl/ifmap_packer_if.sv
// Streaming bus between the raw ifmap source, the packer and the IFmap buffer.
// The packer sits on the slave side: it consumes in_* and produces out_*.
interface ifmap_packer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH+1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/ifmap_packer.sv
// Packs one ifmap row into tagged words {tag, sample} for the IFmap buffer,
// optionally followed by a zero flush row of filter_size words.
// Tags: first word 2'b10, last 2'b01, middle 2'b00, single-word row 2'b11.
module ifmap_packer #(
  parameter int DATA_WIDTH        = 16,
  parameter int LEN_WIDTH         = 8,
  parameter int FILTER_SIZE_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         row_len,
  input  logic [FILTER_SIZE_WIDTH-1:0] filter_size,
  input  logic                         flush_en,
  ifmap_packer_if.slave                bus,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  rowLen_q;
  logic [LEN_WIDTH-1:0]  flushLen_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  flushGo_q;
  logic [DATA_WIDTH+1:0] outData_q;
  logic                  outValid_q;
  logic                  done_q;

  logic                  outFree;
  logic                  dataFire;
  logic                  flushFire;
  logic [LEN_WIDTH-1:0]  curLen;
  logic                  firstWord;
  logic                  lastWord;
  logic [1:0]            tag;

  // The single output register can take a new word when empty or draining.
  assign outFree   = !outValid_q || bus.out_ready;
  assign dataFire  = (state_q == DATA) && outFree && bus.in_valid;
  assign flushFire = (state_q == FLUSH) && outFree;
  assign curLen    = (state_q == FLUSH) ? flushLen_q : rowLen_q;
  assign firstWord = (cnt_q == '0);
  assign lastWord  = (cnt_q == (curLen - LEN_WIDTH'(1)));
  assign tag       = {firstWord, lastWord};

  assign bus.in_ready  = (state_q == DATA) && outFree;
  assign bus.out_data  = outData_q;
  assign bus.out_valid = outValid_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

  // Row sequencer plus output register; DONE waits for the final word to
  // leave the output register so done marks the cycle after the last transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rowLen_q   <= '0;
      flushLen_q <= '0;
      cnt_q      <= '0;
      flushGo_q  <= 1'b0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rowLen_q   <= row_len;
            flushLen_q <= LEN_WIDTH'(filter_size);
            flushGo_q  <= flush_en && (filter_size != '0);
            cnt_q      <= '0;
            if (row_len != '0) begin
              state_q <= DATA;
            end else if (flush_en && (filter_size != '0)) begin
              state_q <= FLUSH;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DATA: begin
          if (dataFire) begin
            outData_q  <= {tag, bus.in_data};
            outValid_q <= 1'b1;
            if (lastWord) begin
              cnt_q   <= '0;
              state_q <= flushGo_q ? FLUSH : DONE;
            end else begin
              cnt_q <= cnt_q + LEN_WIDTH'(1);
            end
          end else if (bus.out_ready) begin
            outValid_q <= 1'b0;
          end
        end
        FLUSH: begin
          if (flushFire) begin
            outData_q  <= {tag, {DATA_WIDTH{1'b0}}};
            outValid_q <= 1'b1;
            if (lastWord) begin
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + LEN_WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (outFree) begin
            outValid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_packer.sv
// Self-checking bench for ifmap_packer: a reference model expands each job
// into its expected tagged words, and a monitor pops and compares them.
module tb_ifmap_packer;
  localparam int DW = 16;
  localparam int LW = 8;
  localparam int FW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] row_len = '0;
  logic [FW-1:0] filter_size = '0;
  logic          flush_en = 1'b0;
  logic          busy;
  logic          done;

  ifmap_packer_if #(.DATA_WIDTH(DW)) bus();

  ifmap_packer #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .FILTER_SIZE_WIDTH(FW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .row_len(row_len),
    .filter_size(filter_size), .flush_en(flush_en), .bus(bus),
    .busy(busy), .done(done)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [DW+1:0] expQ[$];
  int lastEndCyc = -10;
  int emptyDoneCyc = -10;
  int firstValidCyc = -1;
  int xferCount = 0;
  int readyMode = 0;
  logic prevStall = 1'b0;
  logic [DW+1:0] prevData = '0;

  // Cycle counter used to time the expected done pulses
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d",
               name, actual, expected, cyc);
    end
  endtask

  // Monitor: compares every transfer, stall stability and done timing
  always @(negedge clk) begin
    logic expDone;
    logic [DW+1:0] exp;
    if (reset) begin
      expDone = (cyc == lastEndCyc + 1) || (cyc == emptyDoneCyc);
      if (done || expDone) checkOutput("done_pulse", 32'(done), 32'(expDone));
      if (prevStall) begin
        checkOutput("stall_hold_data", 32'(bus.out_data), 32'(prevData));
        checkOutput("stall_hold_valid", 32'(bus.out_valid), 32'd1);
      end
      if (bus.out_valid && firstValidCyc < 0) firstValidCyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word actual=0x%0h required=none at cycle %0d",
                   bus.out_data, cyc);
        end else begin
          exp = expQ.pop_front();
          checkOutput("out_word", 32'(bus.out_data), 32'(exp));
          xferCount++;
          if (expQ.size() == 0) lastEndCyc = cyc;
        end
      end
      prevStall = bus.out_valid && !bus.out_ready;
      prevData  = bus.out_data;
    end else begin
      prevStall = 1'b0;
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = 1,0,0,1 pattern
  initial begin
    int patIdx = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        1: bus.out_ready = 1'($urandom_range(0, 1));
        2: bus.out_ready = ((patIdx % 4) == 0) || ((patIdx % 4) == 3);
        default: bus.out_ready = 1'b1;
      endcase
      patIdx++;
    end
  end

  // One job: model the expected words, pulse start, feed samples, await end.
  // base >= 0 gives samples base, base+1, ...; otherwise samples are random.
  task automatic applyStimulus(input int len, input int fsize, input bit fen,
                               input int validPct, input bit spurious,
                               input bit fullRate, input int base);
    logic [DW-1:0] samples[$];
    logic [DW-1:0] s;
    logic accepted;
    int budget;
    int hs;
    int nWords;
    budget = 0;
    while (busy && budget < 500) begin
      @(posedge clk); #1; budget++;
    end
    if (busy) begin
      errors++; checks++;
      $display("[TB] FAIL idle_timeout actual=busy required=idle");
    end
    nWords = 0;
    for (int i = 0; i < len; i++) begin
      s = (base >= 0) ? DW'(base + i) : DW'($urandom);
      samples.push_back(s);
      expQ.push_back({(i == 0), (i == len - 1), s});
      nWords++;
    end
    if (fen && fsize != 0) begin
      for (int i = 0; i < fsize; i++) begin
        expQ.push_back({(i == 0), (i == fsize - 1), {DW{1'b0}}});
        nWords++;
      end
    end
    if (nWords == 0) emptyDoneCyc = cyc + 2;
    firstValidCyc = -1;
    start = 1'b1; row_len = LW'(len); filter_size = FW'(fsize); flush_en = fen;
    @(posedge clk); #1;
    start = 1'b0;
    row_len = LW'($urandom); filter_size = FW'($urandom); flush_en = 1'($urandom);
    hs = 0; budget = 0;
    while (samples.size() > 0 && budget < 2000) begin
      bus.in_valid = ($urandom_range(0, 99) < validPct);
      bus.in_data  = bus.in_valid ? samples[0] : DW'($urandom);
      if (spurious && hs == 2) begin
        start = 1'b1; row_len = LW'(3); flush_en = 1'b1; filter_size = FW'(4);
        spurious = 1'b0;
      end
      @(negedge clk);
      accepted = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (accepted) begin
        void'(samples.pop_front());
        hs++;
      end
      budget++;
    end
    bus.in_valid = 1'b0;
    if (samples.size() > 0) begin
      errors++; checks++;
      $display("[TB] FAIL input_timeout actual=%0d left required=0", samples.size());
    end
    budget = 0;
    while ((expQ.size() > 0 || busy) && budget < 2000) begin
      @(posedge clk); #1; budget++;
    end
    if (expQ.size() > 0 || busy) begin
      errors++; checks++;
      $display("[TB] FAIL drain_timeout actual=%0d pending required=0", expQ.size());
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    if (fullRate && nWords > 0)
      checkOutput("no_bubble_span", 32'(lastEndCyc - firstValidCyc + 1), 32'(nWords));
  endtask

  // Main sequence
  initial begin
    int budget;
    int idx;
    logic accepted;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    readyMode = 0;
    applyStimulus(12, 0, 1'b0, 100, 1'b0, 1'b1, 1);
    applyStimulus(12, 5, 1'b1, 100, 1'b0, 1'b1, 1);
    readyMode = 2;
    repeat (3) applyStimulus(4, 0, 1'b0, 100, 1'b0, 1'b0, -1);
    applyStimulus(4, 3, 1'b1, 100, 1'b0, 1'b0, -1);
    readyMode = 0;
    applyStimulus(1, 0, 1'b0, 100, 1'b0, 1'b1, 7);
    applyStimulus(0, 0, 1'b0, 100, 1'b0, 1'b0, -1);
    applyStimulus(0, 0, 1'b1, 100, 1'b0, 1'b0, -1);
    applyStimulus(0, 3, 1'b1, 100, 1'b0, 1'b1, -1);
    applyStimulus(1, 1, 1'b1, 100, 1'b0, 1'b1, -1);
    applyStimulus(8, 0, 1'b0, 100, 1'b1, 1'b1, -1);

    // Reset in the middle of an 8-word row
    for (int i = 0; i < 8; i++) expQ.push_back({(i == 0), (i == 7), DW'(100 + i)});
    start = 1'b1; row_len = LW'(8); filter_size = '0; flush_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    idx = xferCount; budget = 0;
    bus.in_valid = 1'b1;
    begin
      int i = 0;
      while (xferCount < idx + 3 && budget < 100) begin
        bus.in_data = DW'(100 + i);
        @(negedge clk);
        accepted = bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        if (accepted) i++;
        budget++;
      end
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrow_reset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrow_reset_busy", 32'(busy), 32'd0);
    checkOutput("midrow_reset_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("midrow_reset_quiet", 32'(bus.out_valid), 32'd0);
    expQ.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(2, 0, 1'b0, 100, 1'b0, 1'b1, -1);

    // Randomized jobs under random backpressure and input gaps
    readyMode = 1;
    repeat (30) begin
      applyStimulus($urandom_range(0, 20), $urandom_range(0, 6), 1'($urandom),
                    70, 1'($urandom_range(0, 3) == 0), 1'b0, -1);
    end

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
